pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Stall/flush responder for the 5-stage pipeline.
- Consumes ID-stage source indices and ID_EX-stage control (MR, rd, branch/jump resolution).
- Drives the flush/stall controls that the IF_ID/ID_EX/EX_MEM registers and PC consume.
- Handles load-use bubbles, taken-branch/jump redirects and multi-cycle data-memory waits, with a wait timeout.

Parameters:
XLEN, 32, datapath/PC width
MEM_TIMEOUT, 64, max consecutive data-memory wait cycles before error (>=2)
CNT_W, 32, perf counter width (used only with HAZ_PERF_CNT_EN)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
id_rs1  in  5  ID-stage source reg 1
id_rs2  in  5  ID-stage source reg 2
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
ex_mr  in  1  memory-read flag from ID_EX (a load is in EX)
ex_rd  in  5  destination reg from ID_EX
ex_br_taken  in  1  conditional branch in EX resolved taken
ex_jmp  in  1  jal in EX
ex_jalr  in  1  jalr in EX
ex_target  in  XLEN  computed target from EX
mem_req  in  1  MEM stage has a load/store outstanding
mem_ready  in  1  data memory completes this cycle
pc_we  out  1  PC update enable
ifid_we  out  1  IF_ID load enable
idex_we  out  1  ID_EX load enable
exmem_we  out  1  EX_MEM load enable
ifid_flush  out  1  zero IF_ID next edge
idex_flush  out  1  drive ID_EX flush
redirect_valid  out  1  PC mux selects redirect_pc
redirect_pc  out  XLEN  redirect target
mem_err  out  1  sticky memory-timeout error

Behaviour:
- Derived signals:
  - ex_redir = ex_br_taken | ex_jmp | ex_jalr.
  - load_use = ex_mr & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
  - x0 never creates a hazard.
- FSM states: RUN, MEM_WAIT, ERR. Also wait_cnt (clog2(MEM_TIMEOUT+1) bits) and a mem_err register.
- Reset, rst high at a clock edge: state<=RUN, wait_cnt<=0, mem_err<=0.
- Outputs while rst is high:
  - pc_we, ifid_we, idex_we, exmem_we = 0
  - ifid_flush, idex_flush = 1
  - redirect_valid = 0, redirect_pc = 0
- Reset mid-wait or in ERR returns to RUN on the same edge.
- Outputs are combinational from state and inputs. Default: all *_we = 1, flushes = 0, redirect_valid = 0, redirect_pc = ex_target.
- Priority, highest first: memory freeze > redirect > load-use.
- RUN:
  - mem_req & !mem_ready: freeze, i.e. all *_we = 0 and no flush. Next state MEM_WAIT, wait_cnt<=1.
  - Else ex_redir: redirect_valid=1, ifid_flush=1, idex_flush=1, pc_we=1. For jalr, redirect_pc = ex_target with bit0 cleared.
  - Else load_use: pc_we=0, ifid_we=0, idex_flush=1. Exactly one bubble; the hazard clears naturally once the load leaves EX.
  - Redirect and load_use in the same cycle: redirect wins, because the ID instruction is wrong-path.
- MEM_WAIT:
  - !mem_ready: freeze held, wait_cnt++. When wait_cnt reaches MEM_TIMEOUT-1 and mem_ready is still low: next state ERR, mem_err<=1.
  - mem_ready: freeze released in this cycle. Redirect and load-use are evaluated as in RUN. Next state RUN, wait_cnt<=0.
- ERR: permanent freeze with mem_err=1 until rst; mem_ready is ignored.
- mem_ready with mem_req low: ignored.
- A mem_req that is ready in the same cycle causes no stall.
- Latency: redirect and bubble take effect on the same edge as detection. The penalty is 2 flushed instructions per redirect and 1 bubble per load-use.

Optional Feature:
HAZ_PERF_CNT_EN
- Defined: adds outputs perf_bubbles, perf_flushes, perf_memwait, each CNT_W wide, saturating, cleared by rst.
  - perf_bubbles increments per load-use bubble.
  - perf_flushes increments per redirect.
  - perf_memwait increments per frozen cycle, including ERR.
- Undefined: these ports and their logic are absent; behaviour is otherwise identical.

Decomposition:
- Package pipe_ctrl_pkg: XLEN, REG_IDX_W=5, state enum {RUN, MEM_WAIT, ERR}, helper constant for the wait_cnt width.
- One natural sub-module: hazard_perf_cnt, a saturating counter instantiated three times and present only under HAZ_PERF_CNT_EN.
- The load_use/ex_redir compares stay inline.

Test Plan:
- Reset: rst=1 for 2 cycles -> all *_we=0, both flushes=1, mem_err=0. First cycle after release with no hazards: all *_we=1.
- Load-use: ex_mr=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 -> pc_we=0, ifid_we=0, idex_flush=1 for exactly 1 cycle. Repeat with ex_rd=0 -> no stall.
- Jalr redirect: ex_jalr=1, ex_target=0x0000_1003 -> redirect_valid=1, redirect_pc=0x0000_1002, ifid_flush=idex_flush=1. Add a simultaneous load_use -> ifid_we stays 1 and redirect wins.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles then 1 -> freeze for 3 cycles, released in the ready cycle, back to RUN. With HAZ_PERF_CNT_EN, perf_memwait=3.
- Timeout: MEM_TIMEOUT=4, mem_ready held low -> mem_err=1 after 4 frozen cycles and stays set despite a later mem_ready. rst clears it.
- Redirect arriving during MEM_WAIT with mem_ready=0 -> no redirect_valid until the ready cycle, then redirect asserted that cycle.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;
  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} haz_state_e;

  // Width of the memory-wait counter so it can hold MEM_TIMEOUT.
  function automatic int wait_cnt_w(input int timeout);
    return $clog2(timeout + 1);
  endfunction
endpackage

// File: rtl/hazard_perf_cnt.sv
// Saturating event counter; only built when HAZ_PERF_CNT_EN is defined.
`ifdef HAZ_PERF_CNT_EN
module hazard_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk) begin
    if (rst)                    cnt <= '0;
    else if (inc && cnt != '1)  cnt <= cnt + 1'b1;
  end
endmodule
`endif

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/redirect control for the 5-stage pipeline with data-memory wait timeout.
// Optional perf counters under HAZ_PERF_CNT_EN.
module pipe_hazard_ctrl #(
  parameter int XLEN        = 32,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [pipe_ctrl_pkg::REG_IDX_W-1:0]  id_rs1,
  input  logic [pipe_ctrl_pkg::REG_IDX_W-1:0]  id_rs2,
  input  logic                                 id_uses_rs1,
  input  logic                                 id_uses_rs2,
  input  logic                                 ex_mr,
  input  logic [pipe_ctrl_pkg::REG_IDX_W-1:0]  ex_rd,
  input  logic                                 ex_br_taken,
  input  logic                                 ex_jmp,
  input  logic                                 ex_jalr,
  input  logic [XLEN-1:0]                      ex_target,
  input  logic                                 mem_req,
  input  logic                                 mem_ready,
  output logic                                 pc_we,
  output logic                                 ifid_we,
  output logic                                 idex_we,
  output logic                                 exmem_we,
  output logic                                 ifid_flush,
  output logic                                 idex_flush,
  output logic                                 redirect_valid,
  output logic [XLEN-1:0]                      redirect_pc,
  output logic                                 mem_err
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]                     perf_bubbles,
  output logic [CNT_W-1:0]                     perf_flushes,
  output logic [CNT_W-1:0]                     perf_memwait
`endif
);
  import pipe_ctrl_pkg::*;

  localparam int WCW = wait_cnt_w(MEM_TIMEOUT);

  haz_state_e       state, state_nx;
  logic [WCW-1:0]   wait_cnt, wait_cnt_nx;
  logic             mem_err_nx;
  logic             ex_redir, load_use, freeze;

  assign ex_redir = ex_br_taken | ex_jmp | ex_jalr;
  assign load_use = ex_mr && (ex_rd != '0) &&
                    ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));

  // A ready response in the same cycle as the request never stalls.
  always_comb begin
    freeze = 1'b0;
    case (state)
      RUN:      freeze = mem_req && !mem_ready;
      MEM_WAIT: freeze = !mem_ready;
      ERR:      freeze = 1'b1;
      default:  freeze = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
      mem_err  <= mem_err_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    wait_cnt_nx = wait_cnt;
    mem_err_nx  = mem_err;
    case (state)
      RUN: if (mem_req && !mem_ready) begin
        state_nx    = MEM_WAIT;
        wait_cnt_nx = WCW'(1);
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          state_nx    = RUN;
          wait_cnt_nx = '0;
        end else if (wait_cnt == WCW'(MEM_TIMEOUT - 1)) begin
          state_nx   = ERR;
          mem_err_nx = 1'b1;
        end else begin
          wait_cnt_nx = wait_cnt + 1'b1;
        end
      end
      default: state_nx = ERR;
    endcase
  end

  // Priority: memory freeze, then redirect (ID is wrong-path), then load-use bubble.
  always_comb begin
    pc_we          = 1'b1;
    ifid_we        = 1'b1;
    idex_we        = 1'b1;
    exmem_we       = 1'b1;
    ifid_flush     = 1'b0;
    idex_flush     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = ex_target;
    if (rst) begin
      {pc_we, ifid_we, idex_we, exmem_we} = 4'b0000;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      redirect_pc = '0;
    end else if (freeze) begin
      {pc_we, ifid_we, idex_we, exmem_we} = 4'b0000;
    end else if (ex_redir) begin
      redirect_valid = 1'b1;
      ifid_flush     = 1'b1;
      idex_flush     = 1'b1;
      if (ex_jalr) redirect_pc = {ex_target[XLEN-1:1], 1'b0};
    end else if (load_use) begin
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      idex_flush = 1'b1;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic ev_bubble, ev_flush, ev_wait;
  assign ev_bubble = !rst && !freeze && !ex_redir && load_use;
  assign ev_flush  = !rst && !freeze && ex_redir;
  assign ev_wait   = !rst && freeze;

  hazard_perf_cnt #(.CNT_W(CNT_W)) u_cnt_bubbles (.clk(clk), .rst(rst), .inc(ev_bubble), .cnt(perf_bubbles));
  hazard_perf_cnt #(.CNT_W(CNT_W)) u_cnt_flushes (.clk(clk), .rst(rst), .inc(ev_flush),  .cnt(perf_flushes));
  hazard_perf_cnt #(.CNT_W(CNT_W)) u_cnt_memwait (.clk(clk), .rst(rst), .inc(ev_wait),   .cnt(perf_memwait));
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized bench for pipe_hazard_ctrl against a rule-level model (MEM_TIMEOUT=4).
module tb_pipe_hazard_ctrl;
  localparam int XLEN = 32;
  localparam int TO   = 4;
  localparam int CW   = 32;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_uses_rs1, id_uses_rs2, ex_mr, ex_br_taken, ex_jmp, ex_jalr, mem_req, mem_ready;
  logic [XLEN-1:0] ex_target, redirect_pc;
  logic pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_flush, redirect_valid, mem_err;
  logic [7:0] obs;
`ifdef HAZ_PERF_CNT_EN
  logic [CW-1:0] perf_bubbles, perf_flushes, perf_memwait;
  int m_bub, m_fl, m_mw;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  bit m_err, m_waiting;
  int m_frozen;
  logic [7:0] e;
  logic [XLEN-1:0] epc;

  pipe_hazard_ctrl #(.XLEN(XLEN), .MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_mr(ex_mr), .ex_rd(ex_rd),
    .ex_br_taken(ex_br_taken), .ex_jmp(ex_jmp), .ex_jalr(ex_jalr), .ex_target(ex_target),
    .mem_req(mem_req), .mem_ready(mem_ready), .pc_we(pc_we), .ifid_we(ifid_we),
    .idex_we(idex_we), .exmem_we(exmem_we), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .mem_err(mem_err)
`ifdef HAZ_PERF_CNT_EN
    , .perf_bubbles(perf_bubbles), .perf_flushes(perf_flushes), .perf_memwait(perf_memwait)
`endif
  );

  always #5 clk = ~clk;
  assign obs = {pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_flush, redirect_valid, mem_err};

  function automatic bit m_is_frozen();
    if (m_err) return 1'b1;
    if (m_waiting) return !mem_ready;
    return mem_req && !mem_ready;
  endfunction

  function automatic bit m_redir();
    return ex_br_taken || ex_jmp || ex_jalr;
  endfunction

  function automatic bit m_lu();
    return ex_mr && ex_rd != 0 &&
           ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
  endfunction

  // Expected {pc_we,ifid_we,idex_we,exmem_we,ifid_flush,idex_flush,redirect_valid,mem_err}.
  task automatic model_exp(output logic [7:0] ev, output logic [XLEN-1:0] pc);
    pc = ex_target;
    if (rst) begin ev = {7'b0000_110, m_err}; pc = '0; end
    else if (m_is_frozen()) ev = {7'b0000_000, m_err};
    else if (m_redir()) begin
      ev = {7'b1111_111, m_err};
      if (ex_jalr) pc = ex_target & ~32'd1;
    end
    else if (m_lu()) ev = {7'b0011_010, m_err};
    else ev = {7'b1111_000, m_err};
  endtask

  task automatic adv();
    @(posedge clk);
`ifdef HAZ_PERF_CNT_EN
    if (rst) begin m_bub = 0; m_fl = 0; m_mw = 0; end
    else if (m_is_frozen()) m_mw++;
    else if (m_redir()) m_fl++;
    else if (m_lu()) m_bub++;
`endif
    if (rst) begin m_err = 0; m_waiting = 0; m_frozen = 0; end
    else if (!m_err) begin
      if (m_is_frozen()) begin
        m_frozen++;
        m_waiting = 1;
        if (m_frozen >= TO) m_err = 1;
      end else begin
        m_waiting = 0;
        m_frozen = 0;
      end
    end
    #1;
  endtask

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    ex_mr = 0; ex_rd = 0; ex_br_taken = 0; ex_jmp = 0; ex_jalr = 0;
    ex_target = 32'h0000_0400; mem_req = 0; mem_ready = 0;
  endtask

  task automatic test_reset();
    idle(); rst = 1; adv();
    for (int i = 0; i < 3; i++) begin
      if (i == 2) rst = 0;
      @(negedge clk); model_exp(e, epc);
      n_cmp++; if (obs !== e) begin n_bad++; $display("FAIL reset_ctl[%0d]: got %b want %b", i, obs, e); end
      n_cmp++; if (redirect_pc !== epc) begin n_bad++; $display("FAIL reset_pc[%0d]: got %h want %h", i, redirect_pc, epc); end
      adv();
    end
  endtask

  task automatic test_load_use();
    for (int i = 0; i < 4; i++) begin
      idle();
      id_rs2 = 5; id_uses_rs2 = 1; ex_rd = 5; ex_mr = 1;
      if (i == 1) ex_mr = 0;
      if (i == 2) begin ex_rd = 0; id_rs2 = 0; end
      if (i == 3) begin ex_rd = 7; id_rs1 = 7; id_uses_rs1 = 1; end
      @(negedge clk); model_exp(e, epc);
      n_cmp++; if (obs !== e) begin n_bad++; $display("FAIL load_use[%0d]: got %b want %b", i, obs, e); end
      adv();
    end
  endtask

  task automatic test_jalr();
    for (int i = 0; i < 3; i++) begin
      idle();
      ex_jalr = 1; ex_target = 32'h0000_1003;
      if (i == 1) begin ex_mr = 1; ex_rd = 3; id_rs1 = 3; id_uses_rs1 = 1; end
      if (i == 2) begin ex_jalr = 0; ex_br_taken = 1; end
      @(negedge clk); model_exp(e, epc);
      n_cmp++; if (obs !== e) begin n_bad++; $display("FAIL jalr_ctl[%0d]: got %b want %b", i, obs, e); end
      n_cmp++; if (redirect_pc !== epc) begin n_bad++; $display("FAIL jalr_pc[%0d]: got %h want %h", i, redirect_pc, epc); end
      adv();
    end
  endtask

  task automatic test_mem_wait();
    for (int i = 0; i < 6; i++) begin
      idle();
      mem_req = (i < 4); mem_ready = (i == 3) || (i == 5);
      if (i == 4) begin ex_mr = 1; ex_rd = 9; id_rs1 = 9; id_uses_rs1 = 1; end
      @(negedge clk); model_exp(e, epc);
      n_cmp++; if (obs !== e) begin n_bad++; $display("FAIL mem_wait[%0d]: got %b want %b", i, obs, e); end
      adv();
    end
  endtask

  task automatic test_redir_in_wait();
    for (int i = 0; i < 4; i++) begin
      idle();
      mem_req = 1; mem_ready = (i == 2); ex_jmp = (i >= 1 && i <= 2); ex_target = 32'h0000_2000;
      if (i == 3) mem_req = 0;
      @(negedge clk); model_exp(e, epc);
      n_cmp++; if (obs !== e) begin n_bad++; $display("FAIL redir_wait[%0d]: got %b want %b", i, obs, e); end
      n_cmp++; if (redirect_pc !== epc) begin n_bad++; $display("FAIL redir_wait_pc[%0d]: got %h want %h", i, redirect_pc, epc); end
      adv();
    end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 11; i++) begin
      idle();
      mem_req = (i < 9); mem_ready = (i >= 6 && i < 9); ex_jmp = (i == 7);
      rst = (i == 9);
      @(negedge clk); model_exp(e, epc);
      n_cmp++; if (obs !== e) begin n_bad++; $display("FAIL timeout[%0d]: got %b want %b", i, obs, e); end
      adv();
    end
    rst = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 99) < 2);
      id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
      ex_rd = 5'($urandom_range(0, 3));
      id_uses_rs1 = 1'($urandom); id_uses_rs2 = 1'($urandom); ex_mr = 1'($urandom);
      ex_br_taken = ($urandom_range(0, 9) == 0); ex_jmp = ($urandom_range(0, 11) == 0);
      ex_jalr = ($urandom_range(0, 11) == 0); ex_target = $urandom;
      mem_req = ($urandom_range(0, 3) == 0); mem_ready = ($urandom_range(0, 9) < 6);
      @(negedge clk); model_exp(e, epc);
      n_cmp++; if (obs !== e) begin n_bad++; $display("FAIL rand_ctl[%0d]: got %b want %b", i, obs, e); end
      n_cmp++; if (redirect_pc !== epc) begin n_bad++; $display("FAIL rand_pc[%0d]: got %h want %h", i, redirect_pc, epc); end
`ifdef HAZ_PERF_CNT_EN
      n_cmp++;
      if (perf_bubbles !== CW'(m_bub) || perf_flushes !== CW'(m_fl) || perf_memwait !== CW'(m_mw)) begin
        n_bad++;
        $display("FAIL rand_perf[%0d]: got %0d/%0d/%0d want %0d/%0d/%0d", i,
                 perf_bubbles, perf_flushes, perf_memwait, m_bub, m_fl, m_mw);
      end
`endif
      adv();
    end
    rst = 0;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_jalr();
    test_mem_wait();
    test_redir_in_wait();
    test_timeout();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
